mem_run_controller: RTL and testbench
=====================================

// Module: mem_run_controller
// PURPOSE
//  Sequences the delay-line memory manager for the test harness. Owns its run and mem_params
//  inputs. Forces a clean restart (run low for a fixed time) on start or on any params change.
//  Queues host replace-number requests and issues them only while running.
//  Drains received-number reports with the ack handshake into a valid/ready stream for the UART TX.
// PARAMETERS
//  PARAMS_W       32  width of memory-manager params word (no_nums/test_mode/pulse_width/gap)
//  REPLACE_W      24  width of replace-number packet (addr+data)
//  RECEIVED_W     24  width of received-number packet (addr+data)
//  FIFO_DEPTH     4   replace-request FIFO entries, power of 2, >=2
//  RESTART_CYCLES 16  clocks run is held low in RESTART, >=2
// PORTS
//  clk                   in  1           system clock, all logic posedge
//  n_reset               in  1           asynchronous, active-low reset
//  cmd_params            in  PARAMS_W    new params word
//  cmd_params_valid      in  1           1-cycle pulse: latch cmd_params
//  cmd_start             in  1           1-cycle pulse: start/restart memory
//  cmd_stop              in  1           1-cycle pulse: stop memory
//  cmd_replace           in  REPLACE_W   replace request packet
//  cmd_replace_valid     in  1           request present
//  cmd_replace_ready     out 1           FIFO not full
//  run                   out 1           registered; to mem manager run
//  mem_params            out PARAMS_W    registered; to mem manager params
//  mem_replace_num       out REPLACE_W   registered; to mem manager
//  mem_replace_valid     out 1           registered 1-cycle write strobe
//  mem_received_num      in  RECEIVED_W  report from mem manager
//  mem_received_replaced in  1           report was a replacement
//  mem_received_valid    in  1           report present (drops combinationally on ack)
//  mem_received_overrun  in  1           sticky overrun from mem manager
//  mem_received_ack      out 1           registered 1-cycle ack
//  tx_num                out RECEIVED_W  report to UART TX
//  tx_replaced           out 1           replaced flag to UART TX
//  tx_valid              out 1           report held for TX
//  tx_ready              in  1           TX accepts when tx_valid&&tx_ready
//  state                 out 2           0 IDLE, 1 RESTART, 2 RUNNING
//  overrun_count         out 8           saturating count of overrun rising edges
// BEHAVIOUR
//  Reset values: all outputs 0, except cmd_replace_ready=1. State=IDLE, FIFO empty, overrun edge reg 0.
//  FSM, priority stop > params > start:
//   IDLE: cmd_start -> RESTART. cmd_params_valid latches params and stays in IDLE, unless start is also high.
//   RESTART: run=0. Counter runs 0..RESTART_CYCLES-1, then -> RUNNING. cmd_stop -> IDLE.
//     cmd_params_valid latches params and clears the counter.
//   RUNNING: run=1. cmd_stop -> IDLE. cmd_params_valid latches params -> RESTART.
//     cmd_start -> RESTART (re-sync).
//  run is registered with the state: it goes low on the same edge mem_params changes.
//  mem_params never changes while run=1.
//  cmd_start -> run high exactly RESTART_CYCLES+1 edges after the start pulse edge.
//  cmd_start clears overrun_count.
//  Replace FIFO:
//   push on cmd_replace_valid&&cmd_replace_ready.
//   cmd_replace_ready = !full.
//   Pop only in RUNNING, one entry per 2 clocks: strobe, then 1 idle. Pop drives mem_replace_num
//     and pulses mem_replace_valid.
//   Entries are held, not popped, in IDLE/RESTART.
//   cmd_stop flushes the FIFO; a push in the same cycle is dropped.
//   Simultaneous push+pop when full is not allowed (ready=0). Push+pop otherwise keeps the count.
//  Report path, RUNNING only:
//   If mem_received_valid && !tx_valid && !mem_received_ack:
//     capture num/replaced into tx_*, set tx_valid, pulse mem_received_ack next cycle.
//   tx_valid clears on tx_ready. A new capture may occur the cycle after clear.
//   If tx_valid is held, do not ack. The mem manager flags the overrun.
//   In IDLE/RESTART: no ack. A pending tx_* is retained until consumed.
//  overrun_count: +1 on each 0->1 of mem_received_overrun, saturating at 255.
//   The sticky input falls when run falls.
// TESTING
//  1 Reset mid-RUNNING:
//    n_reset low async -> run=0, state=0, tx_valid=0, mem_replace_valid=0, ready=1 same cycle.
//  2 RESTART_CYCLES=16: params=0x12345678+start pulse at t0 -> mem_params=0x12345678 at t0+1,
//    run=1 at t0+17.
//  3 In RUNNING, params pulse -> run=0 next edge, mem_params updated same edge,
//    run=1 16 edges later. Params pulse at RESTART count 10 -> count restarts.
//  4 Push 5 replaces with FIFO_DEPTH=4 in IDLE -> 5th sees ready=0. After start, 4 strobes
//    spaced 2 clocks in FIFO order, after run=1. Stop with 2 queued -> flushed, no strobes.
//  5 Report 0x00A055 with tx_ready=0 -> tx_num=0x00A055, one ack. A 2nd report is not acked
//    until tx_ready; overrun rise -> overrun_count=1. 256 rises -> saturates at 255.
//  6 cmd_stop+cmd_start same cycle in RUNNING -> state IDLE, run=0, overrun_count not cleared.

Source files
------------

// File: rtl/mem_run_controller.sv
// mem_run_controller
//   Sequences the delay-line memory manager. Holds run low for a fixed
//   restart window on every start or params change, queues host
//   replace-number requests and only issues them while running, and turns
//   the memory manager's valid/ack report handshake into a valid/ready
//   stream for the UART TX.
//
// Ports
//   clk, n_reset                 clock, async active-low reset
//   cmd_params/_valid            new params word, 1-cycle latch pulse
//   cmd_start, cmd_stop          1-cycle control pulses
//   cmd_replace/_valid/_ready    replace request push interface
//   run, mem_params              registered controls to the memory manager
//   mem_replace_num/_valid       registered replace write strobe
//   mem_received_*               report interface from the memory manager
//   mem_received_ack             registered 1-cycle report ack
//   tx_num/tx_replaced/tx_valid  report stream to the UART TX, tx_ready in
//   state                        0 IDLE, 1 RESTART, 2 RUNNING
//   overrun_count                saturating count of overrun rising edges
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | run low, FIFO held, no reports acked
// RESTART  | run low for RESTART_CYCLES clocks, then RUNNING
// RUNNING  | run high, replace strobes issued, reports drained to TX

module mem_run_controller #(
  parameter int PARAMS_W       = 32,
  parameter int REPLACE_W      = 24,
  parameter int RECEIVED_W     = 24,
  parameter int FIFO_DEPTH     = 4,
  parameter int RESTART_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [PARAMS_W-1:0]   cmd_params,
  input  logic                  cmd_params_valid,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic [REPLACE_W-1:0]  cmd_replace,
  input  logic                  cmd_replace_valid,
  output logic                  cmd_replace_ready,
  output logic                  run,
  output logic [PARAMS_W-1:0]   mem_params,
  output logic [REPLACE_W-1:0]  mem_replace_num,
  output logic                  mem_replace_valid,
  input  logic [RECEIVED_W-1:0] mem_received_num,
  input  logic                  mem_received_replaced,
  input  logic                  mem_received_valid,
  input  logic                  mem_received_overrun,
  output logic                  mem_received_ack,
  output logic [RECEIVED_W-1:0] tx_num,
  output logic                  tx_replaced,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [1:0]            state,
  output logic [7:0]            overrun_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (RESTART_CYCLES > 2) ? $clog2(RESTART_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RCNT_LOAD = CNT_W'(RESTART_CYCLES - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTART = 2'd1,
    ST_RUNNING = 2'd2
  } state_e;

  state_e              state_q;
  logic                run_q;
  logic [PARAMS_W-1:0] params_q;
  logic [CNT_W-1:0]    rcnt_q;

  // A start that loses to a simultaneous stop has no effect at all.
  logic start_go;
  assign start_go = cmd_start && !cmd_stop;

  // Restart timer is a down-counter loaded with RESTART_CYCLES-1 on entry;
  // terminal count 0 moves to RUNNING, giving RESTART_CYCLES clocks of run=0.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      params_q <= '0;
      rcnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cmd_stop) begin
            if (cmd_params_valid) params_q <= cmd_params;
            if (cmd_start) begin
              state_q <= ST_RESTART;
              rcnt_q  <= RCNT_LOAD;
            end
          end
        end
        ST_RESTART: begin
          if (cmd_stop) begin
            state_q <= ST_IDLE;
          end else if (cmd_params_valid) begin
            params_q <= cmd_params;
            rcnt_q   <= RCNT_LOAD;
          end else if (cmd_start) begin
            rcnt_q <= RCNT_LOAD;
          end else if (rcnt_q == '0) begin
            state_q <= ST_RUNNING;
            run_q   <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q - 1'b1;
          end
        end
        ST_RUNNING: begin
          if (cmd_stop) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
          end else if (cmd_params_valid || cmd_start) begin
            // run drops on the same edge the new params appear
            if (cmd_params_valid) params_q <= cmd_params;
            state_q <= ST_RESTART;
            run_q   <= 1'b0;
            rcnt_q  <= RCNT_LOAD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  // Overrun edge counter
  logic       ovr_q;
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      ovr_q <= mem_received_overrun;
      if (start_go) begin
        ovr_cnt_q <= '0;
      end else if (mem_received_overrun && !ovr_q && (ovr_cnt_q != 8'hFF)) begin
        ovr_cnt_q <= ovr_cnt_q + 8'd1;
      end
    end
  end

  // Replace FIFO
  logic [REPLACE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W:0]       fcnt_q;
  logic                 gap_q;
  logic                 rv_q;
  logic [REPLACE_W-1:0] rnum_q;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign full  = (fcnt_q == FIFO_FULL);
  assign empty = (fcnt_q == '0);
  // stop flushes, so a push or pop in the same cycle is discarded
  assign push  = cmd_replace_valid && !full && !cmd_stop;
  // gap_q forces one idle clock after every strobe
  assign pop   = (state_q == ST_RUNNING) && !empty && !gap_q && !cmd_stop;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_replace;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      gap_q    <= 1'b0;
      rv_q     <= 1'b0;
      rnum_q   <= '0;
    end else begin
      gap_q <= pop;
      rv_q  <= pop;
      if (pop) rnum_q <= fifo_mem[rd_ptr_q];
      if (cmd_stop) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fcnt_q   <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   fcnt_q <= fcnt_q + 1'b1;
          2'b01:   fcnt_q <= fcnt_q - 1'b1;
          default: fcnt_q <= fcnt_q;
        endcase
      end
    end
  end

  // Report path. The ack term keeps the report still visible during the
  // ack cycle from being captured twice.
  logic                  ack_q;
  logic                  txv_q;
  logic [RECEIVED_W-1:0] txn_q;
  logic                  txr_q;
  logic                  cap;

  assign cap = (state_q == ST_RUNNING) && mem_received_valid && !txv_q && !ack_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ack_q <= 1'b0;
      txv_q <= 1'b0;
      txn_q <= '0;
      txr_q <= 1'b0;
    end else begin
      ack_q <= cap;
      if (cap) begin
        txv_q <= 1'b1;
        txn_q <= mem_received_num;
        txr_q <= mem_received_replaced;
      end else if (txv_q && tx_ready) begin
        txv_q <= 1'b0;
      end
    end
  end

  assign cmd_replace_ready = !full;
  assign run               = run_q;
  assign mem_params        = params_q;
  assign mem_replace_num   = rnum_q;
  assign mem_replace_valid = rv_q;
  assign mem_received_ack  = ack_q;
  assign tx_num            = txn_q;
  assign tx_replaced       = txr_q;
  assign tx_valid          = txv_q;
  assign state             = state_q;
  assign overrun_count     = ovr_cnt_q;

endmodule

// File: tb/tb_mem_run_controller.sv
module tb_mem_run_controller;

  logic        clk;
  logic        n_reset;
  logic [31:0] cmd_params;
  logic        cmd_params_valid;
  logic        cmd_start;
  logic        cmd_stop;
  logic [23:0] cmd_replace;
  logic        cmd_replace_valid;
  logic        cmd_replace_ready;
  logic        run;
  logic [31:0] mem_params;
  logic [23:0] mem_replace_num;
  logic        mem_replace_valid;
  logic [23:0] mem_received_num;
  logic        mem_received_replaced;
  logic        mem_received_valid;
  logic        mem_received_overrun;
  logic        mem_received_ack;
  logic [23:0] tx_num;
  logic        tx_replaced;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  state;
  logic [7:0]  overrun_count;

  // report source: valid drops combinationally on ack
  logic rep_req;
  assign mem_received_valid = rep_req && !mem_received_ack;

  mem_run_controller #(
    .PARAMS_W(32), .REPLACE_W(24), .RECEIVED_W(24),
    .FIFO_DEPTH(4), .RESTART_CYCLES(16)
  ) dut (
    .clk(clk), .n_reset(n_reset),
    .cmd_params(cmd_params), .cmd_params_valid(cmd_params_valid),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_replace(cmd_replace), .cmd_replace_valid(cmd_replace_valid),
    .cmd_replace_ready(cmd_replace_ready),
    .run(run), .mem_params(mem_params),
    .mem_replace_num(mem_replace_num), .mem_replace_valid(mem_replace_valid),
    .mem_received_num(mem_received_num), .mem_received_replaced(mem_received_replaced),
    .mem_received_valid(mem_received_valid), .mem_received_overrun(mem_received_overrun),
    .mem_received_ack(mem_received_ack),
    .tx_num(tx_num), .tx_replaced(tx_replaced), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .state(state), .overrun_count(overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ticks until run is high, bounded
  task automatic wait_run(output int n);
    n = 0;
    while (!run && n < 60) begin
      tick();
      n++;
    end
  endtask

  // scoreboards
  logic [23:0] rep_exp_q[$];
  logic [24:0] tx_exp_q[$];
  int strobe_cnt = 0;
  int ack_cnt = 0;
  int cyc = 0;
  int last_strobe = -1;
  logic [31:0] prev_params = '0;
  logic prev_run = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (n_reset) begin
      if (mem_received_ack) ack_cnt++;
      if (mem_replace_valid) begin
        strobe_cnt++;
        chk("strobe_while_run", {31'd0, run}, 32'd1);
        if (rep_exp_q.size() == 0) begin
          chk("strobe_unexpected", {8'd0, mem_replace_num}, 32'hFFFFFFFF);
        end else begin
          chk("strobe_data", {8'd0, mem_replace_num}, {8'd0, rep_exp_q.pop_front()});
          if (last_strobe >= 0) chk("strobe_spacing", cyc - last_strobe, 32'd2);
          last_strobe = (rep_exp_q.size() == 0) ? -1 : cyc;
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_exp_q.size() == 0)
          chk("tx_unexpected", {7'd0, tx_replaced, tx_num}, 32'hFFFFFFFF);
        else
          chk("tx_handshake", {7'd0, tx_replaced, tx_num}, {7'd0, tx_exp_q.pop_front()});
      end
      if (run && prev_run) chk("params_stable_while_run", mem_params, prev_params);
    end
    prev_params = mem_params;
    prev_run = run;
  end

  typedef struct {
    logic        pv;
    logic        st;
    logic        sp;
    logic [31:0] prm;
    logic [1:0]  exp_state;
    logic        exp_run;
    logic [31:0] exp_prm;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int sc;
    logic [7:0] exp_ovr;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h11110001, 2'd0, 1'b0, 32'h11110001};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,        2'd1, 1'b0, 32'h11110001};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0,        2'd1, 1'b0, 32'h11110001};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0,        2'd0, 1'b0, 32'h11110001};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h22220002, 2'd1, 1'b0, 32'h22220002};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0,        2'd0, 1'b0, 32'h22220002};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 32'h22220002};

    n_reset = 1'b0;
    cmd_params = '0; cmd_params_valid = 0; cmd_start = 0; cmd_stop = 0;
    cmd_replace = '0; cmd_replace_valid = 0;
    mem_received_num = '0; mem_received_replaced = 0; rep_req = 0;
    mem_received_overrun = 0; tx_ready = 0;
    #13;
    chk("rst_ready", {31'd0, cmd_replace_ready}, 32'd1);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_params", mem_params, 32'd0);
    chk("rst_outs", {28'd0, mem_replace_valid, mem_received_ack, tx_valid, tx_replaced}, 32'd0);
    n_reset = 1'b1;
    tick();

    // command/FSM vector table
    for (int i = 0; i < 7; i++) begin
      cmd_params_valid = vecs[i].pv;
      cmd_start = vecs[i].st;
      cmd_stop = vecs[i].sp;
      cmd_params = vecs[i].prm;
      tick();
      cmd_params_valid = 0; cmd_start = 0; cmd_stop = 0;
      chk($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].exp_state});
      chk($sformatf("vec%0d_run", i), {31'd0, run}, {31'd0, vecs[i].exp_run});
      chk($sformatf("vec%0d_params", i), mem_params, vecs[i].exp_prm);
    end

    // start latency
    cmd_params = 32'h12345678; cmd_params_valid = 1; cmd_start = 1;
    tick();
    cmd_params_valid = 0; cmd_start = 0;
    chk("start_params", mem_params, 32'h12345678);
    chk("start_run_low", {31'd0, run}, 32'd0);
    wait_run(n);
    chk("start_to_run_edges", n + 1, 32'd17);
    chk("start_state_running", {30'd0, state}, 32'd2);

    // params change while running
    cmd_params = 32'hCAFEF00D; cmd_params_valid = 1;
    tick();
    cmd_params_valid = 0;
    chk("prm_run_low", {31'd0, run}, 32'd0);
    chk("prm_value", mem_params, 32'hCAFEF00D);
    wait_run(n);
    chk("prm_restart_edges", n, 32'd16);

    // params again during RESTART restarts the window
    cmd_params = 32'h0BADBEEF; cmd_params_valid = 1;
    tick();
    cmd_params_valid = 0;
    repeat (10) tick();
    cmd_params = 32'h5A5A5A5A; cmd_params_valid = 1;
    tick();
    cmd_params_valid = 0;
    chk("prm2_value", mem_params, 32'h5A5A5A5A);
    chk("prm2_state", {30'd0, state}, 32'd1);
    wait_run(n);
    chk("prm2_restart_edges", n, 32'd16);

    // replace FIFO: fill in IDLE, drain after start
    cmd_stop = 1; tick(); cmd_stop = 0;
    chk("stop_idle", {30'd0, state}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cmd_replace = 24'h5A0000 + i * 24'h010101;
      cmd_replace_valid = 1;
      chk($sformatf("push%0d_ready", i), {31'd0, cmd_replace_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) rep_exp_q.push_back(cmd_replace);
      tick();
    end
    cmd_replace_valid = 0;
    repeat (6) tick();
    chk("held_in_idle", strobe_cnt, 32'd0);
    cmd_start = 1; tick(); cmd_start = 0;
    repeat (8) tick();
    chk("held_in_restart", strobe_cnt, 32'd0);
    wait_run(n);
    repeat (10) tick();
    chk("drain_count", strobe_cnt, 32'd4);
    chk("drain_queue_empty", rep_exp_q.size(), 32'd0);

    // stop flushes queued entries; push alongside stop is dropped
    cmd_stop = 1; tick(); cmd_stop = 0;
    for (int i = 0; i < 2; i++) begin
      cmd_replace = 24'hE00000 + i; cmd_replace_valid = 1;
      tick();
    end
    cmd_replace = 24'hDEAD00; cmd_stop = 1;
    tick();
    cmd_stop = 0; cmd_replace_valid = 0;
    chk("flush_ready", {31'd0, cmd_replace_ready}, 32'd1);
    sc = strobe_cnt;
    cmd_start = 1; tick(); cmd_start = 0;
    wait_run(n);
    repeat (10) tick();
    chk("flush_no_strobes", strobe_cnt, sc);

    // report path
    mem_received_num = 24'h00A055; mem_received_replaced = 1; rep_req = 1;
    tx_exp_q.push_back({1'b1, 24'h00A055});
    tick();
    rep_req = 0;
    chk("rpt1_tx_valid", {31'd0, tx_valid}, 32'd1);
    chk("rpt1_tx_num", {8'd0, tx_num}, 32'h00A055);
    chk("rpt1_ack", {31'd0, mem_received_ack}, 32'd1);
    tick();
    chk("rpt1_ack_count", ack_cnt, 32'd1);
    mem_received_num = 24'h00B0AA; mem_received_replaced = 0; rep_req = 1;
    tx_exp_q.push_back({1'b0, 24'h00B0AA});
    repeat (4) tick();
    chk("rpt2_held_no_ack", ack_cnt, 32'd1);
    chk("rpt2_tx_retained", {8'd0, tx_num}, 32'h00A055);
    mem_received_overrun = 1;
    tick();
    chk("ovr_first", {24'd0, overrun_count}, 32'd1);
    tx_ready = 1; tick(); tx_ready = 0;
    chk("tx_cleared", {31'd0, tx_valid}, 32'd0);
    tick();
    rep_req = 0;
    chk("rpt2_tx_valid", {31'd0, tx_valid}, 32'd1);
    chk("rpt2_tx_num", {7'd0, tx_replaced, tx_num}, {7'd0, 1'b0, 24'h00B0AA});
    tick();
    chk("rpt2_ack_count", ack_cnt, 32'd2);
    chk("tx_queue_one_left", tx_exp_q.size(), 32'd1);

    // overrun saturation
    exp_ovr = 8'd1;
    for (int i = 0; i < 300; i++) begin
      mem_received_overrun = 0; tick();
      mem_received_overrun = 1; tick();
      if (exp_ovr != 8'hFF) exp_ovr++;
      if (i == 99) chk("ovr_101", {24'd0, overrun_count}, {24'd0, exp_ovr});
    end
    chk("ovr_saturate", {24'd0, overrun_count}, 32'd255);

    // stop + start together in RUNNING
    cmd_stop = 1; cmd_start = 1; tick(); cmd_stop = 0; cmd_start = 0;
    chk("stopstart_state", {30'd0, state}, 32'd0);
    chk("stopstart_run", {31'd0, run}, 32'd0);
    chk("stopstart_ovr_kept", {24'd0, overrun_count}, 32'd255);
    chk("tx_retained_idle", {31'd0, tx_valid}, 32'd1);
    cmd_start = 1; tick(); cmd_start = 0;
    chk("start_clears_ovr", {24'd0, overrun_count}, 32'd0);

    // async reset while running
    wait_run(n);
    chk("pre_reset_run", {31'd0, run}, 32'd1);
    @(posedge clk); #3;
    n_reset = 0;
    #1;
    chk("areset_run", {31'd0, run}, 32'd0);
    chk("areset_state", {30'd0, state}, 32'd0);
    chk("areset_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("areset_replace_valid", {31'd0, mem_replace_valid}, 32'd0);
    chk("areset_ready", {31'd0, cmd_replace_ready}, 32'd1);
    #10;
    n_reset = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
